// File: rtl/hilo_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : hilo_ctrl
// Brief    : Execute-stage HI/LO sequencer: launches the shared multiplier or
//            divider with operand magnitudes, sign-corrects results, owns HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_ctrl #(
    parameter bit DIV0_KEEP = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        mul_start,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic        mul_done,
    input  logic [63:0] mul_c,
    output logic        div_start,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic        div_done,
    input  logic [63:0] div_c,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_mul   = 2'd1;
    localparam logic [1:0] c_st_div   = 2'd2;
    localparam logic [1:0] c_st_drain = 2'd3;

    localparam logic [2:0] c_op_mult  = 3'd0;
    localparam logic [2:0] c_op_multu = 3'd1;
    localparam logic [2:0] c_op_div   = 3'd2;
    localparam logic [2:0] c_op_divu  = 3'd3;
    localparam logic [2:0] c_op_mthi  = 3'd4;
    localparam logic [2:0] c_op_mtlo  = 3'd5;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic        r_neg_q;      // quotient / product sign: nega ^ negb
    logic        r_neg_r;      // remainder sign: nega
    logic        r_raw;        // divide-by-zero launched: write result uncorrected
    logic        r_unit_div;   // which unit a DRAIN is waiting on
    logic        r_mul_start;
    logic        r_div_start;
    logic [31:0] r_mul_a;
    logic [31:0] r_mul_b;
    logic [31:0] r_div_a;
    logic [31:0] r_div_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_is_mul;
    logic        w_is_div;
    logic        w_is_mt;
    logic        w_hilo_req;
    logic        w_signed;
    logic        w_b_zero;
    logic        w_div_skip;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic        w_stall;
    logic        w_launch_mul;
    logic        w_launch_div;
    logic        w_wr_mt;
    logic        w_wr_mul;
    logic        w_wr_div;
    logic [63:0] w_mul_res;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_is_mul   = (req_op == c_op_mult) || (req_op == c_op_multu);
    assign w_is_div   = (req_op == c_op_div)  || (req_op == c_op_divu);
    assign w_is_mt    = (req_op == c_op_mthi) || (req_op == c_op_mtlo);
    assign w_hilo_req = req_valid && (w_is_mul || w_is_div || w_is_mt);
    assign w_signed   = (req_op == c_op_mult) || (req_op == c_op_div);
    assign w_b_zero   = (req_b == 32'd0);
    assign w_div_skip = w_is_div && w_b_zero && DIV0_KEEP;
    assign w_neg_a    = w_signed && req_a[31];
    assign w_neg_b    = w_signed && req_b[31];
    assign w_mag_a    = w_neg_a ? (32'd0 - req_a) : req_a;
    assign w_mag_b    = w_neg_b ? (32'd0 - req_b) : req_b;

    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_launch_mul = 1'b0;
        w_launch_div = 1'b0;
        w_wr_mt      = 1'b0;
        w_wr_mul     = 1'b0;
        w_wr_div     = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (req_valid && !flush) begin
                    if (w_is_mul) begin
                        w_launch_mul = 1'b1;
                        w_stall      = 1'b1;
                        w_state_next = c_st_mul;
                    end else if (w_is_div && !w_div_skip) begin
                        w_launch_div = 1'b1;
                        w_stall      = 1'b1;
                        w_state_next = c_st_div;
                    end else if (w_is_mt) begin
                        w_wr_mt = 1'b1;
                    end
                end
            end
            c_st_mul: begin
                if (flush) begin
                    w_state_next = mul_done ? c_st_idle : c_st_drain;
                end else if (mul_done) begin
                    w_wr_mul     = 1'b1;
                    w_state_next = c_st_idle;
                end else begin
                    w_stall = 1'b1;
                end
            end
            c_st_div: begin
                if (flush) begin
                    w_state_next = div_done ? c_st_idle : c_st_drain;
                end else if (div_done) begin
                    w_wr_div     = 1'b1;
                    w_state_next = c_st_idle;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: begin
                // New HI/LO ops wait here until the abandoned unit reports done.
                w_stall = w_hilo_req && !flush;
                if (r_unit_div ? div_done : mul_done) begin
                    w_state_next = c_st_idle;
                end
            end
        endcase
    end

    assign w_mul_res = r_neg_q ? (64'd0 - mul_c) : mul_c;
    assign w_quo     = (r_neg_q && !r_raw) ? (32'd0 - div_c[31:0])  : div_c[31:0];
    assign w_rem     = (r_neg_r && !r_raw) ? (32'd0 - div_c[63:32]) : div_c[63:32];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= c_st_idle;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_raw       <= 1'b0;
            r_unit_div  <= 1'b0;
            r_mul_start <= 1'b0;
            r_div_start <= 1'b0;
            r_mul_a     <= 32'd0;
            r_mul_b     <= 32'd0;
            r_div_a     <= 32'd0;
            r_div_b     <= 32'd0;
        end else begin
            r_state     <= w_state_next;
            r_mul_start <= w_launch_mul;
            r_div_start <= w_launch_div;
            if (w_launch_mul || w_launch_div) begin
                r_neg_q    <= w_neg_a ^ w_neg_b;
                r_neg_r    <= w_neg_a;
                r_raw      <= w_launch_div && w_b_zero;
                r_unit_div <= w_launch_div;
            end
            if (w_launch_mul) begin
                r_mul_a <= w_mag_a;
                r_mul_b <= w_mag_b;
            end
            if (w_launch_div) begin
                r_div_a <= w_mag_a;
                r_div_b <= w_mag_b;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_wr_mul) begin
            r_hi <= w_mul_res[63:32];
            r_lo <= w_mul_res[31:0];
        end else if (w_wr_div) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
        end else if (w_wr_mt) begin
            if (req_op == c_op_mthi) begin
                r_hi <= req_a;
            end else begin
                r_lo <= req_a;
            end
        end
    end

    assign stall     = w_stall;
    assign busy      = (r_state != c_st_idle);
    assign mul_start = r_mul_start;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign div_start = r_div_start;
    assign div_a     = r_div_a;
    assign div_b     = r_div_b;
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_hilo_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_hilo_ctrl
// Brief    : Directed self-checking bench for hilo_ctrl with latency-4 unit models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hilo_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic        flush = 1'b0;
    logic        stall, busy, mul_start, div_start;
    logic [31:0] mul_a, mul_b, div_a, div_b, hi, lo;
    logic        mul_done = 1'b0;
    logic        div_done = 1'b0;
    logic [63:0] mul_c = 64'd0;
    logic [63:0] div_c = 64'd0;

    int n_checks = 0;
    int n_fail   = 0;

    hilo_ctrl #(.DIV0_KEEP(1'b1)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .flush(flush), .stall(stall), .busy(busy),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done),
        .mul_c(mul_c), .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_done(div_done), .div_c(div_c), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Unit models: done arrives 4 cycles after the start cycle; unaffected by resetn.
    logic [2:0]  m_cnt = 3'd0, d_cnt = 3'd0;
    logic [31:0] m_a = 32'd0, m_b = 32'd0, d_a = 32'd0, d_b = 32'd0;
    always @(posedge clk) begin
        mul_done <= 1'b0;
        if (mul_start) begin
            m_cnt <= 3'd3; m_a <= mul_a; m_b <= mul_b;
        end else if (m_cnt != 3'd0) begin
            m_cnt <= m_cnt - 3'd1;
            if (m_cnt == 3'd1) begin
                mul_done <= 1'b1;
                mul_c    <= {32'd0, m_a} * {32'd0, m_b};
            end
        end
    end
    always @(posedge clk) begin
        div_done <= 1'b0;
        if (div_start) begin
            d_cnt <= 3'd3; d_a <= div_a; d_b <= div_b;
        end else if (d_cnt != 3'd0) begin
            d_cnt <= d_cnt - 3'd1;
            if (d_cnt == 3'd1) begin
                div_done <= 1'b1;
                div_c    <= (d_b == 32'd0) ? {d_a, 32'hFFFF_FFFF} : {d_a % d_b, d_a / d_b};
            end
        end
    end

    task automatic cyc(input logic v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic f);
        @(negedge clk);
        req_valid = v; req_op = op; req_a = a; req_b = b; flush = f;
        #1;
    endtask

    // Presents one op and holds it while stalled; returns in the cycle after it retires.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int stalls, output int starts,
                          output logic [31:0] ca, output logic [31:0] cb, output bit tmo);
        stalls = 0; starts = 0; ca = 32'd0; cb = 32'd0; tmo = 1'b1;
        cyc(1'b1, op, a, b, 1'b0);
        for (int k = 0; k < 40; k++) begin
            if (mul_start || div_start) begin
                starts++;
                ca = mul_start ? mul_a : div_a;
                cb = mul_start ? mul_b : div_b;
            end
            if (!stall) begin
                tmo = 1'b0;
                break;
            end
            stalls++;
            cyc(1'b1, op, a, b, 1'b0);
        end
        cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic test_reset();
        #2 resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
            n_checks++;
            if (hi !== 32'd0 || lo !== 32'd0 || stall !== 1'b0 || busy !== 1'b0 ||
                mul_start !== 1'b0 || div_start !== 1'b0 || mul_a !== 32'd0 ||
                mul_b !== 32'd0 || div_a !== 32'd0 || div_b !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: hi=%h lo=%h stall=%b busy=%b ms=%b ds=%b, expected all zero",
                         k, hi, lo, stall, busy, mul_start, div_start);
            end
        end
    endtask

    task automatic test_mult();
        int st, sp; logic [31:0] ca, cb; bit tmo;
        run_op(3'd0, 32'hFFFF_FFFD, 32'd5, st, sp, ca, cb, tmo);
        n_checks++; if (tmo) begin n_fail++; $display("FAIL mult_timeout: stall never dropped, expected drop"); end
        n_checks++; if (st != 5) begin n_fail++; $display("FAIL mult_stall_cycles: got %0d expected 5", st); end
        n_checks++; if (sp != 1) begin n_fail++; $display("FAIL mult_start_pulses: got %0d expected 1", sp); end
        n_checks++; if (ca !== 32'd3 || cb !== 32'd5) begin n_fail++; $display("FAIL mult_operands: got %h/%h expected 3/5", ca, cb); end
        n_checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mult_result: got %h_%h expected ffffffff_fffffff1", hi, lo); end
    endtask

    task automatic test_div();
        int st, sp; logic [31:0] ca, cb; bit tmo;
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, st, sp, ca, cb, tmo);
        n_checks++; if (tmo || st != 5 || sp != 1) begin n_fail++; $display("FAIL div_handshake: stalls=%0d starts=%0d tmo=%0d expected 5/1/0", st, sp, tmo); end
        n_checks++; if (ca !== 32'd7 || cb !== 32'd2) begin n_fail++; $display("FAIL div_operands: got %h/%h expected 7/2", ca, cb); end
        n_checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_result: got hi=%h lo=%h expected ffffffff/fffffffd", hi, lo); end
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, st, sp, ca, cb, tmo);
        n_checks++; if (ca !== 32'hFFFF_FFF9 || sp != 1) begin n_fail++; $display("FAIL divu_operands: got %h starts=%0d expected fffffff9/1", ca, sp); end
        n_checks++; if (hi !== 32'd1 || lo !== 32'h7FFF_FFFC) begin n_fail++; $display("FAIL divu_result: got hi=%h lo=%h expected 1/7ffffffc", hi, lo); end
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, st, sp, ca, cb, tmo);
        n_checks++; if (ca !== 32'h8000_0000 || cb !== 32'd1) begin n_fail++; $display("FAIL div_wrap_operands: got %h/%h expected 80000000/1", ca, cb); end
        n_checks++; if (hi !== 32'd0 || lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_wrap_result: got hi=%h lo=%h expected 0/80000000", hi, lo); end
    endtask

    task automatic test_div0_keep();
        int st, sp; logic [31:0] ca, cb; bit tmo;
        run_op(3'd3, 32'd7, 32'd0, st, sp, ca, cb, tmo);
        n_checks++; if (st != 0 || sp != 0 || div_start !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL div0_no_launch: stalls=%0d starts=%0d ds=%b busy=%b expected 0/0/0/0", st, sp, div_start, busy); end
        n_checks++; if (hi !== 32'd0 || lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div0_hilo_kept: got hi=%h lo=%h expected 0/80000000", hi, lo); end
        run_op(3'd5, 32'h1234, 32'd0, st, sp, ca, cb, tmo);
        n_checks++; if (st != 0 || lo !== 32'h1234 || hi !== 32'd0) begin n_fail++; $display("FAIL mtlo: stalls=%0d hi=%h lo=%h expected 0/0/1234", st, hi, lo); end
        run_op(3'd4, 32'h5678, 32'd0, st, sp, ca, cb, tmo);
        n_checks++; if (hi !== 32'h5678 || lo !== 32'h1234) begin n_fail++; $display("FAIL mthi: got hi=%h lo=%h expected 5678/1234", hi, lo); end
    endtask

    task automatic test_idle_flush();
        cyc(1'b1, 3'd4, 32'hDEAD, 32'd0, 1'b1);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL idle_flush_mthi_stall: got %b expected 0", stall); end
        cyc(1'b1, 3'd0, 32'd3, 32'd3, 1'b1);
        n_checks++; if (hi !== 32'h5678 || stall !== 1'b0) begin n_fail++; $display("FAIL idle_flush_mthi: hi=%h stall=%b expected 5678/0", hi, stall); end
        cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        n_checks++; if (mul_start !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_flush_mult: ms=%b busy=%b expected 0/0", mul_start, busy); end
    endtask

    task automatic test_flush_drain();
        int st, sp; logic [31:0] ca, cb; bit tmo; bit idle;
        cyc(1'b1, 3'd0, 32'd2, 32'd3, 1'b0);
        cyc(1'b1, 3'd0, 32'd2, 32'd3, 1'b0);
        n_checks++; if (mul_start !== 1'b1) begin n_fail++; $display("FAIL flush_launch: mul_start=%b expected 1", mul_start); end
        cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_cycle_stall: got %b expected 0", stall); end
        cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL drain_busy: got %b expected 1", busy); end
        idle = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (!busy) begin idle = 1'b1; break; end
            cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        end
        n_checks++; if (!idle) begin n_fail++; $display("FAIL drain_exit: busy still 1 expected 0"); end
        n_checks++; if (hi !== 32'h5678 || lo !== 32'h1234) begin n_fail++; $display("FAIL drain_discard: got hi=%h lo=%h expected 5678/1234", hi, lo); end
        cyc(1'b1, 3'd0, 32'd2, 32'd3, 1'b0);
        cyc(1'b1, 3'd0, 32'd2, 32'd3, 1'b0);
        cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        run_op(3'd1, 32'd6, 32'd7, st, sp, ca, cb, tmo);
        n_checks++; if (tmo || st != 8) begin n_fail++; $display("FAIL drain_then_multu_stalls: got %0d tmo=%0d expected 8/0", st, tmo); end
        n_checks++; if (sp != 1 || ca !== 32'd6 || cb !== 32'd7) begin n_fail++; $display("FAIL drain_then_multu_launch: starts=%0d ops=%h/%h expected 1/6/7", sp, ca, cb); end
        n_checks++; if (hi !== 32'd0 || lo !== 32'd42) begin n_fail++; $display("FAIL drain_then_multu_result: got hi=%h lo=%h expected 0/2a", hi, lo); end
    endtask

    task automatic test_reset_mid_div();
        bit seen_done;
        cyc(1'b1, 3'd2, 32'd100, 32'd7, 1'b0);
        cyc(1'b1, 3'd2, 32'd100, 32'd7, 1'b0);
        n_checks++; if (div_start !== 1'b1) begin n_fail++; $display("FAIL rst_div_launch: div_start=%b expected 1", div_start); end
        @(negedge clk);
        resetn = 1'b0; req_valid = 1'b0;
        #1;
        n_checks++; if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_div: hi=%h lo=%h busy=%b stall=%b expected 0/0/0/0", hi, lo, busy, stall); end
        @(negedge clk);
        resetn = 1'b1;
        seen_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
            if (div_done) seen_done = 1'b1;
        end
        n_checks++; if (!seen_done) begin n_fail++; $display("FAIL rst_stale_done_seen: got 0 expected 1"); end
        n_checks++; if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_stale_done_ignored: hi=%h lo=%h busy=%b expected 0/0/0", hi, lo, busy); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div0_keep();
        test_idle_flush();
        test_flush_drain();
        test_reset_mid_div();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/hilo_ctrl.md
# hilo_ctrl

Sequencing controller for the execute-stage HI/LO resource. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from issue slot 1 and launches the shared multicycle multiplier or divider with operand magnitudes. It applies sign correction to the result, owns the architectural HI/LO registers and stalls the pipeline while an operation is in flight. It sits beside the ALUs in execute; MFHI/MFLO read its `hi`/`lo` outputs directly.

## Interface
- `DIV0_KEEP`, 1: divide by zero skips the divider and leaves HI/LO unchanged. When 0, the divider is launched normally and its raw result is written.
- `clk` in 1: single clock; all state on rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: slot-1 instruction in execute is a HI/LO op.
- `req_op` in 3: op code. 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 ignored.
- `req_a`, `req_b` in 32: rs/rt values.
- `flush` in 1: kill the current slot-1 instruction and any in-flight op.
- `stall` out 1: hold execute and earlier stages.
- `busy` out 1: state ≠ IDLE.
- `mul_start` out 1: one-cycle launch pulse.
- `mul_a`, `mul_b` out 32: magnitudes.
- `mul_done` in 1, `mul_c` in 64: unsigned product.
- `div_start` out 1: one-cycle launch pulse.
- `div_a`, `div_b` out 32: magnitudes.
- `div_done` in 1, `div_c` in 64: {remainder, quotient} unsigned.
- `hi`, `lo` out 32: architectural registers.

## Operation
- States: IDLE, MUL, DIV, DRAIN.
- Signed ops (MULT, DIV):
  - nega = a[31], negb = b[31].
  - Operands sent as two's-complement magnitudes; unsigned ops send raw values.
  - Both signs are latched at launch.
- IDLE, req_valid, !flush:
  - MULT/MULTU: `mul_start`=1 → MUL, `stall`=1.
  - DIV/DIVU with b≠0, or b=0 with DIV0_KEEP=0: `div_start`=1 → DIV, `stall`=1.
  - DIV/DIVU with b=0 and DIV0_KEEP=1: no launch, no stall, HI/LO unchanged.
  - MTHI/MTLO: `hi`/`lo` ← req_a at edge, no stall.
- MUL: `stall`=1 until the `mul_done` cycle. In the done cycle:
  - `stall`=0.
  - {hi,lo} ← (nega^negb) ? −mul_c : mul_c (64-bit negate).
  - → IDLE.
- DIV: same pattern with `div_done`.
  - lo ← quotient, negated if nega^negb.
  - hi ← remainder, negated if nega.
  - 32-bit wrap: 0x80000000 / −1 gives lo=0x80000000, hi=0.
- Held request: while in MUL/DIV the held `req_valid` never relaunches. Launch occurs only from IDLE.
- Flush in MUL/DIV before done:
  - Result discarded, → DRAIN.
  - `stall`=0 in the flush cycle.
- Flush in the done cycle: no HI/LO write, → IDLE.
- DRAIN:
  - Waits for the pending unit's done, discards the result, → IDLE.
  - Any HI/LO-op request arriving in DRAIN gets `stall`=1 and is not accepted until IDLE.
  - Non-HI/LO traffic is not stalled.
- Flush in IDLE: suppresses launch and MTHI/MTLO write.
- Done pulses received in IDLE are ignored.
- Reset mid-op: immediately IDLE; the unit's later done is ignored.

## Timing
- Reset values: hi=0, lo=0, state IDLE, stall=0, busy=0, mul_start=0, div_start=0, mul_a/b=0, div_a/b=0.
- Start pulses are registered: asserted exactly one cycle, in the cycle after acceptance.
- `stall` is combinational from state and request, so it is high in the acceptance cycle.
- Stalled cycles = 1 + unit latency. `stall` drops in the done cycle; HI/LO update at that edge.
- MFHI/MFLO issued next cycle sees new values.
- `mul_a/b`, `div_a/b` are registered with the start pulse and held until done.
- `busy` = registered state ≠ IDLE.

## Test plan
- Reset: after deassertion, hi=lo=0, stall=0, no start pulses for 5 idle cycles.
- MULT, a=0xFFFFFFFD (−3), b=5, unit latency 4:
  - mul_a=3, mul_b=5, one mul_start pulse.
  - stall high 5 cycles.
  - hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV, a=0xFFFFFFF9 (−7), b=2:
  - lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU with the same operands gives lo=0x7FFFFFFC, hi=1.
- DIVU, a=7, b=0, DIV0_KEEP=1:
  - no div_start, stall=0.
  - hi/lo unchanged. MTLO 0x1234 next cycle → lo=0x1234.
- MULT flushed 2 cycles after launch:
  - → DRAIN, stall=0.
  - Following MULTU is stalled until the stale mul_done.
  - Stale result not written; new MULTU result is correct.
- resetn asserted mid-DIV: hi=lo=0, IDLE at once; later div_done causes no write.
